// File: rtl/shared_inc_sched.sv
// Round-robin scheduler sharing one W-bit incrementer (operand + INC, carry kept)
// among N requesters; one op at a time through IDLE -> EXEC -> RESP.
module shared_inc_sched #(
  parameter int             N   = 4,
  parameter int             W   = 2,
  parameter logic [W-1:0]   INC = W'(1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req,
  input  logic [N*W-1:0]     operand,
  output logic [N-1:0]       gnt,
  output logic [N-1:0]       done,
  output logic [N*(W+1)-1:0] result,
  output logic               busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] idx;

  logic [IW-1:0] sel;
  logic [IW-1:0] cand;
  logic          found;
  logic [W:0]    add_a;
  logic [W:0]    add_b;
  logic [W:0]    sum;
  logic [IW-1:0] ptr_next;

  function automatic logic [N-1:0] onehot(input logic [IW-1:0] i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Round-robin pick: first requester at or after ptr, wrapping modulo N.
  always_comb begin
    sel   = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      cand = IW'((int'(ptr) + i) % N);
      if (!found && req[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  // The single shared adder; only meaningful while in EXEC.
  always_comb begin
    add_a = {1'b0, operand[idx*W +: W]};
    add_b = {1'b0, INC};
    sum   = add_a + add_b;
  end

  assign ptr_next = (idx == IW'(N - 1)) ? '0 : idx + 1'b1;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      idx    <= '0;
      gnt    <= '0;
      done   <= '0;
      busy   <= 1'b0;
      // NOTE: the result registers are flops, not RAM, so clearing them in
      // reset is cheap and gives a defined value before the first op.
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state <= EXEC;
            idx   <= sel;
            gnt   <= onehot(sel);
            busy  <= 1'b1;
          end
        end
        EXEC: begin
          result[idx*(W+1) +: W+1] <= sum;
          gnt   <= '0;
          done  <= onehot(idx);
          state <= RESP;
        end
        RESP: begin
          done  <= '0;
          ptr   <= ptr_next;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          done  <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
